// File: rtl/decoder_nx_seq.sv
// rtl/decoder_nx_seq.sv - registered SEL_W-to-2**SEL_W decoder with thermometer, active-low and scan modes
module decoder_nx_seq #(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      sel,
    input  logic [1:0]            mode,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [(1<<SEL_W)-1:0] z,
    output logic                  z_valid,
    output logic                  scan_wrap
);
    localparam int OUT_W = 1 << SEL_W;

    typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;

    state_t             state, state_nx;
    logic [OUT_W-1:0]   z_nx;
    logic               z_valid_nx, scan_wrap_nx;
    logic [SEL_W-1:0]   index, index_nx, start, start_nx, index_inc;
    logic [DWELL_W-1:0] cnt, cnt_nx, dwell_q, dwell_q_nx;
    logic [OUT_W-1:0]   one_hot, therm;

    assign in_ready  = en && (state != SCAN);
    assign index_inc = index + 1'b1;
    assign one_hot   = OUT_W'(1) << sel;

    always_comb begin
        therm = '0;
        for (int i = 0; i < OUT_W; i++) begin
            therm[i] = (SEL_W'(i) <= sel);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            z         <= '0;
            z_valid   <= 1'b0;
            scan_wrap <= 1'b0;
            index     <= '0;
            start     <= '0;
            cnt       <= '0;
            dwell_q   <= '0;
        end else begin
            state     <= state_nx;
            z         <= z_nx;
            z_valid   <= z_valid_nx;
            scan_wrap <= scan_wrap_nx;
            index     <= index_nx;
            start     <= start_nx;
            cnt       <= cnt_nx;
            dwell_q   <= dwell_q_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        z_nx         = z;
        z_valid_nx   = z_valid;
        scan_wrap_nx = 1'b0;
        index_nx     = index;
        start_nx     = start;
        cnt_nx       = cnt;
        dwell_q_nx   = dwell_q;
        if (!en) begin
            state_nx   = IDLE;
            z_nx       = '0;
            z_valid_nx = 1'b0;
        end else if (state == SCAN) begin
            if (cnt == dwell_q) begin
                cnt_nx   = '0;
                index_nx = index_inc;
                // Returning to the start index means every position has been shown once.
                if (index_inc == start) begin
                    state_nx     = IDLE;
                    z_nx         = '0;
                    z_valid_nx   = 1'b0;
                    scan_wrap_nx = 1'b1;
                end else begin
                    z_nx = OUT_W'(1) << index_inc;
                end
            end else begin
                cnt_nx = cnt + 1'b1;
            end
        end else if (in_valid) begin
            z_valid_nx = 1'b1;
            state_nx   = HOLD;
            case (mode)
                2'b00: z_nx = one_hot;
                2'b01: z_nx = therm;
                2'b11: z_nx = ~one_hot;
                default: begin
                    z_nx       = one_hot;
                    state_nx   = SCAN;
                    index_nx   = sel;
                    start_nx   = sel;
                    cnt_nx     = '0;
                    dwell_q_nx = dwell;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_decoder_nx_seq.sv
// tb/tb_decoder_nx_seq.sv - scoreboard bench for decoder_nx_seq
module tb_decoder_nx_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] sel = '0;
    logic [1:0] mode = '0;
    logic [7:0] dwell = '0;
    logic [3:0] z;
    logic       z_valid;
    logic       scan_wrap;

    int tests = 0;
    int fails = 0;
    logic [5:0] exp_q[$];

    decoder_nx_seq #(.SEL_W(2), .DWELL_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .mode(mode), .dwell(dwell), .z(z), .z_valid(z_valid), .scan_wrap(scan_wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Expected output after the next edge: {z, z_valid, scan_wrap}
    task automatic push(input logic [3:0] ez, input logic ewrap);
        exp_q.push_back({ez, ~ewrap, ewrap});
    endtask

    always @(negedge clk) begin
        if (rst_n && (z_valid || scan_wrap)) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got z=%b v=%b w=%b with empty scoreboard at %0t",
                         z, z_valid, scan_wrap, $time);
            end else begin
                check("scoreboard", {2'b00, z, z_valid, scan_wrap}, {2'b00, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset state, plain decode, hold
        cyc(); cyc();
        check("reset_out", {2'b00, z, z_valid, scan_wrap}, 8'd0);
        check("reset_ready_en0", {7'd0, in_ready}, 8'd0);
        rst_n = 1'b1; en = 1'b1;
        #1;
        check("ready_after_reset", {7'd0, in_ready}, 8'd1);
        in_valid = 1'b1; mode = 2'b00; sel = 2'd2;
        push(4'b0100, 1'b0); cyc();
        in_valid = 1'b0; sel = 2'd0;
        for (int i = 0; i < 3; i++) begin push(4'b0100, 1'b0); cyc(); end

        // 2: thermometer back-to-back, active-low
        in_valid = 1'b1; mode = 2'b01; sel = 2'd2; push(4'b0111, 1'b0); cyc();
        sel = 2'd3; push(4'b1111, 1'b0); cyc();
        mode = 2'b11; sel = 2'd0; push(4'b1110, 1'b0); cyc();
        in_valid = 1'b0; push(4'b1110, 1'b0); cyc();

        // 3: scan from 2 with dwell=1; inputs during scan are ignored
        in_valid = 1'b1; mode = 2'b10; sel = 2'd2; dwell = 8'd1;
        push(4'b0100, 1'b0); cyc();
        check("ready_in_scan", {7'd0, in_ready}, 8'd0);
        mode = 2'b00; sel = 2'd1; dwell = 8'd5;
        push(4'b0100, 1'b0); cyc(); in_valid = 1'b0;
        push(4'b1000, 1'b0); cyc(); in_valid = 1'b1;
        push(4'b1000, 1'b0); cyc();
        push(4'b0001, 1'b0); cyc(); in_valid = 1'b0;
        push(4'b0001, 1'b0); cyc();
        push(4'b0010, 1'b0); cyc(); in_valid = 1'b1;
        push(4'b0010, 1'b0); cyc();
        push(4'b0000, 1'b1); cyc();
        in_valid = 1'b0;
        check("ready_after_wrap", {7'd0, in_ready}, 8'd1);
        cyc();
        check("idle_after_wrap", {2'b00, z, z_valid, scan_wrap}, 8'd0);

        // 4: scan from 3 with dwell=0, wraps 3 -> 0
        in_valid = 1'b1; mode = 2'b10; sel = 2'd3; dwell = 8'd0;
        push(4'b1000, 1'b0); cyc();
        in_valid = 1'b0;
        push(4'b0001, 1'b0); cyc();
        push(4'b0010, 1'b0); cyc();
        push(4'b0100, 1'b0); cyc();
        push(4'b0000, 1'b1); cyc();
        cyc();

        // 5: en=0 in HOLD clears and blocks accepts
        in_valid = 1'b1; mode = 2'b00; sel = 2'd1; push(4'b0010, 1'b0); cyc();
        in_valid = 1'b0; en = 1'b0; cyc();
        check("en0_out", {2'b00, z, z_valid, scan_wrap}, 8'd0);
        check("en0_ready", {7'd0, in_ready}, 8'd0);
        in_valid = 1'b1; sel = 2'd3; cyc();
        check("en0_no_accept", {2'b00, z, z_valid, scan_wrap}, 8'd0);
        en = 1'b1; push(4'b1000, 1'b0); cyc();
        in_valid = 1'b0; push(4'b1000, 1'b0); cyc();

        // 6: asynchronous reset mid-scan
        in_valid = 1'b1; mode = 2'b10; sel = 2'd0; dwell = 8'd3;
        push(4'b0001, 1'b0); cyc();
        in_valid = 1'b0; push(4'b0001, 1'b0); cyc();
        @(negedge clk); #2;
        rst_n = 1'b0; #1;
        check("async_reset_out", {2'b00, z, z_valid, scan_wrap}, 8'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("reset_no_wrap", {2'b00, z, z_valid, scan_wrap}, 8'd0);
        end
        rst_n = 1'b1;
        in_valid = 1'b1; mode = 2'b11; sel = 2'd1; push(4'b1101, 1'b0); cyc();
        in_valid = 1'b0; push(4'b1101, 1'b0); cyc();
        @(negedge clk); #1;
        check("scoreboard_drained", 8'(exp_q.size()), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
